freq_display_driver: RTL and testbench

//   Parametrised successor to the fixed 4-digit frequency-display path. It takes a binary

---
 rtl/freq_disp_pkg.sv | 26 ++
 rtl/freq_display_driver_seg7_encode.sv | 27 ++
 rtl/freq_display_driver.sv | 197 +++++++++++++++++++
 tb/tb_freq_display_driver.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_disp_pkg.sv
// Shared types and constants for the frequency display driver.
package freq_disp_pkg;

  // Conversion controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  // Segment patterns in internal active-high form, bit 0 = a .. bit 6 = g.
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_ZERO  = 7'b0111111;

  // 10^n, used to derive the largest displayable value at elaboration time.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_display_driver_seg7_encode.sv
// BCD nibble to 7-segment pattern (active-high, bit 0 = a .. bit 6 = g).
// Codes above 9 are not valid BCD and render as a blank digit.
module seg7_encode
  import freq_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Glyph lookup.
  always_comb begin
    unique case (nibble_i)
      4'd0:    seg_o = SEG_ZERO;
      4'd1:    seg_o = 7'b0000110;
      4'd2:    seg_o = 7'b1011011;
      4'd3:    seg_o = 7'b1001111;
      4'd4:    seg_o = 7'b1100110;
      4'd5:    seg_o = 7'b1101101;
      4'd6:    seg_o = 7'b1111101;
      4'd7:    seg_o = 7'b0000111;
      4'd8:    seg_o = 7'b1111111;
      4'd9:    seg_o = 7'b1101111;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/freq_display_driver.sv
// Frequency display driver: sequential binary-to-BCD conversion (shift-add-3,
// one bit per clock) on a load strobe, then a continuously refreshed
// multiplexed 7-segment display with leading-zero blanking and an overflow dash.
module freq_display_driver
  import freq_disp_pkg::*;
#(
  parameter int unsigned BIN_WIDTH   = 32,
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          DIG_ACT_LOW = 1'b1
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] Dig
);

  localparam int unsigned SCR_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int unsigned REF_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [63:0]           MAX_DISP = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [6:0]            SEG_POL  = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_POL  = {NUM_DIGITS{DIG_ACT_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_ZERO = NUM_DIGITS'(1);

  // Conversion state.
  state_e               state_q,    state_d;
  logic [BIN_WIDTH-1:0] shift_q,    shift_d;
  logic [SCR_W-1:0]     scratch_q,  scratch_d;
  logic [CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic [SCR_W-1:0]     disp_q,     disp_d;
  logic                 overflow_q, overflow_d;
  logic [SCR_W-1:0]     adj;

  // Refresh / output state.
  logic [REF_W-1:0]      ref_cnt_q;
  logic [IDX_W-1:0]      dig_idx_q;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] dig_q;

  logic [NUM_DIGITS-1:0] hi_zero;
  logic                  all_zero;
  logic [3:0]            nibble;
  logic                  hi_zero_sel;
  logic [6:0]            seg_enc;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] dig_next;

  // Controller registers; everything returns to a defined state on reset,
  // so an in-flight conversion and the held display value are both dropped.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      bit_cnt_q  <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      bit_cnt_q  <= bit_cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic: accept load only when idle, shift-add-3 per bit, then commit.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    bit_cnt_d  = bit_cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    adj        = scratch_q;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          shift_d    = bin_in;
          scratch_d  = '0;
          bit_cnt_d  = CNT_W'(BIN_WIDTH);
          ovf_pend_d = (64'(bin_in) > MAX_DISP);
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          if (scratch_q[i*4 +: 4] >= 4'd5) begin
            adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
          end
        end
        // Bits leaving the top of the scratch are dropped; ovf_pend covers them.
        scratch_d = {adj[SCR_W-2:0], shift_q[BIN_WIDTH-1]};
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q - CNT_W'(1);
        if (bit_cnt_q == CNT_W'(1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        disp_d     = scratch_q;
        overflow_d = ovf_pend_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running refresh timer and digit scan index.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q <= '0;
      dig_idx_q <= '0;
    end else if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_cnt_q <= '0;
      dig_idx_q <= (dig_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : dig_idx_q + IDX_W'(1);
    end else begin
      ref_cnt_q <= ref_cnt_q + REF_W'(1);
    end
  end

  // hi_zero[i]: digit i and every more-significant digit are zero.
  always_comb begin
    all_zero = 1'b1;
    hi_zero  = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      all_zero   = all_zero & (disp_q[i*4 +: 4] == 4'd0);
      hi_zero[i] = all_zero;
    end
  end

  // Select the scanned digit and build its one-hot enable.
  always_comb begin
    nibble      = 4'd0;
    hi_zero_sel = 1'b0;
    dig_next    = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (dig_idx_q == IDX_W'(i)) begin
        nibble      = disp_q[i*4 +: 4];
        hi_zero_sel = hi_zero[i];
        dig_next[i] = 1'b1;
      end
    end
  end

  seg7_encode u_seg7 (
    .nibble_i (nibble),
    .seg_o    (seg_enc)
  );

  // Digit content priority: overflow dash, then leading-zero blank, then glyph.
  always_comb begin
    if (overflow_q) begin
      seg_next = SEG_DASH;
    end else if (blank_lz && hi_zero_sel && (dig_idx_q != '0)) begin
      seg_next = SEG_BLANK;
    end else begin
      seg_next = seg_enc;
    end
  end

  // Output registers; polarity is applied only here.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_ZERO ^ SEG_POL;
      dig_q <= DIG_ZERO ^ DIG_POL;
    end else begin
      seg_q <= seg_next ^ SEG_POL;
      dig_q <= dig_next ^ DIG_POL;
    end
  end

  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;
  assign seg      = seg_q;
  assign Dig      = dig_q;

endmodule

// File: tb/tb_freq_display_driver.sv
// Self-checking bench for freq_display_driver: fixed vector table, hand-written
// multi-cycle sequences, and randomized loads checked against an arithmetic model.
module tb_freq_display_driver;

  localparam int REFRESH_DIV = 4;
  localparam int CONV_CYCLES = 33;

  // Active-low glyphs as they appear on the pins.
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bin_in;
  logic        load;
  logic        blank_lz;
  logic        busy;
  logic        overflow;
  logic [6:0]  seg;
  logic [3:0]  Dig;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0]     bin;
    logic            blz;
    logic            ovf;
    logic [3:0][6:0] segs;
  } vec_t;

  vec_t vecs [11];

  freq_display_driver #(
    .BIN_WIDTH   (32),
    .NUM_DIGITS  (4),
    .REFRESH_DIV (REFRESH_DIV),
    .SEG_ACT_LOW (1'b1),
    .DIG_ACT_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bin_in   (bin_in),
    .load     (load),
    .blank_lz (blank_lz),
    .busy     (busy),
    .overflow (overflow),
    .seg      (seg),
    .Dig      (Dig)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference glyph for one decimal digit.
  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return S0;  1: return S1;  2: return S2;  3: return S3;  4: return S4;
      5: return S5;  6: return S6;  7: return S7;  8: return S8;  default: return S9;
    endcase
  endfunction

  // Display model: decimal digits by division, blanking by magnitude.
  function automatic logic [3:0][6:0] model(input longint unsigned v, input bit blz);
    logic [3:0][6:0] r;
    longint unsigned p = 1;
    for (int k = 0; k < 4; k++) begin
      if (v > 9999)                    r[k] = SD;
      else if (blz && k != 0 && v < p) r[k] = SB;
      else                             r[k] = glyph(int'((v / p) % 10));
      p = p * 10;
    end
    return r;
  endfunction

  // Strobe load for one cycle and count cycles with busy high after acceptance.
  task automatic do_load(input logic [31:0] v, output int bcyc);
    @(negedge clk);
    bin_in = v;
    load   = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    bcyc = 0;
    while (busy && bcyc < 200) begin
      @(posedge clk);
      #1 bcyc++;
    end
  endtask

  // Walk one full scan and compare each digit's segments when its enable is seen.
  task automatic scan(input string name, input logic [3:0][6:0] exp);
    logic [3:0] want;
    int n;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      want = ~(4'b0001 << k);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (Dig !== want && n < 40);
      if (Dig !== want) check($sformatf("%s_dig%0d", name, k), 32'(Dig), 32'(want));
      else              check($sformatf("%s_seg%0d", name, k), 32'(seg), 32'(exp[k]));
    end
  endtask

  initial begin
    int bc;
    logic [31:0] v;
    bit blz;

    vecs[0]  = '{bin: 32'd1234,     blz: 1'b0, ovf: 1'b0, segs: {S1, S2, S3, S4}};
    vecs[1]  = '{bin: 32'd7,        blz: 1'b1, ovf: 1'b0, segs: {SB, SB, SB, S7}};
    vecs[2]  = '{bin: 32'd7,        blz: 1'b0, ovf: 1'b0, segs: {S0, S0, S0, S7}};
    vecs[3]  = '{bin: 32'd10000,    blz: 1'b0, ovf: 1'b1, segs: {SD, SD, SD, SD}};
    vecs[4]  = '{bin: 32'd9999,     blz: 1'b0, ovf: 1'b0, segs: {S9, S9, S9, S9}};
    vecs[5]  = '{bin: 32'd0,        blz: 1'b1, ovf: 1'b0, segs: {SB, SB, SB, S0}};
    vecs[6]  = '{bin: 32'd50,       blz: 1'b1, ovf: 1'b0, segs: {SB, SB, S5, S0}};
    vecs[7]  = '{bin: 32'd1005,     blz: 1'b1, ovf: 1'b0, segs: {S1, S0, S0, S5}};
    vecs[8]  = '{bin: 32'd5678,     blz: 1'b0, ovf: 1'b0, segs: {S5, S6, S7, S8}};
    vecs[9]  = '{bin: 32'd10000,    blz: 1'b1, ovf: 1'b1, segs: {SD, SD, SD, SD}};
    vecs[10] = '{bin: 32'hFFFFFFFF, blz: 1'b1, ovf: 1'b1, segs: {SD, SD, SD, SD}};

    // Reset state.
    rst = 1'b1; load = 1'b0; bin_in = '0; blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf",  32'(overflow), 32'd0);
    check("rst_dig",  32'(Dig), 32'b1110);
    check("rst_seg",  32'(seg), 32'(S0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_onehot", 32'($countones(~Dig)), 32'd1);

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      blank_lz = vecs[i].blz;
      do_load(vecs[i].bin, bc);
      check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(CONV_CYCLES));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      scan($sformatf("v%0d", i), vecs[i].segs);
    end

    // blank_lz is sampled live: change it without reloading.
    blank_lz = 1'b1;
    do_load(32'd7, bc);
    scan("live_blz1", {SB, SB, SB, S7});
    blank_lz = 1'b0;
    scan("live_blz0", {S0, S0, S0, S7});

    // Load while busy is ignored.
    do_load(32'd1234, bc);
    @(negedge clk);
    bin_in = 32'd1234; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    bc = 0;
    repeat (2) begin
      @(posedge clk);
      #1 bc++;
    end
    bin_in = 32'd5678; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    bc++;
    while (busy && bc < 200) begin
      @(posedge clk);
      #1 bc++;
    end
    check("ign_busy_cycles", 32'(bc), 32'(CONV_CYCLES));
    scan("ign_disp", model(1234, 1'b0));
    do_load(32'd5678, bc);
    scan("idle_load", model(5678, 1'b0));

    // Reset in the middle of a conversion.
    @(negedge clk);
    bin_in = 32'd4321; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dig",  32'(Dig), 32'b1110);
    check("abort_seg",  32'(seg), 32'(S0));
    check("abort_ovf",  32'(overflow), 32'd0);
    repeat (REFRESH_DIV) @(posedge clk);
    #1 check("abort_ref_hold", 32'(Dig), 32'b1110);
    @(posedge clk);
    #1 check("abort_ref_step", 32'(Dig), 32'b1101);
    scan("abort_disp", model(0, 1'b0));

    // Reset together with load: load dropped.
    @(negedge clk);
    rst = 1'b1; load = 1'b1; bin_in = 32'd99;
    @(posedge clk);
    #1 rst = 1'b0; load = 1'b0;
    @(posedge clk);
    #1 check("rst_load_busy", 32'(busy), 32'd0);

    // Value 0 with blanking: only digit 0 lit, one-hot enables for 3 scans.
    blank_lz = 1'b1;
    do_load(32'd0, bc);
    scan("zero", model(0, 1'b1));
    for (int c = 0; c < 3 * 4 * REFRESH_DIV; c++) begin
      @(negedge clk);
      check("zero_onehot", 32'($countones(~Dig)), 32'd1);
      check("zero_seg", 32'(seg), 32'((Dig == 4'b1110) ? S0 : SB));
    end

    // Randomized loads against the model, plus a live blank_lz flip.
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, 9999);
        2:       v = $urandom_range(9990, 10010);
        default: v = $urandom;
      endcase
      blz = 1'($urandom_range(0, 1));
      blank_lz = blz;
      do_load(v, bc);
      check($sformatf("r%0d_busy_cycles", i), 32'(bc), 32'(CONV_CYCLES));
      check($sformatf("r%0d_ovf", i), 32'(overflow), 32'(v > 9999));
      scan($sformatf("r%0d_v%0d", i, v), model(v, blz));
      blank_lz = ~blz;
      scan($sformatf("r%0d_flip", i), model(v, ~blz));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
